banked_register_file: RTL and testbench
=======================================

Name: banked_register_file

Overview:
- Parametrised successor to the 16x16 CPU register file.
- Two combinational read ports feed R_Bus and S_Bus.
- Two write ports:
  - Port A: D_Bus writeback with per-byte lane enables. This replaces the separate upper/lower write strobes.
  - Port B: D_Addr/memory load return, full word.
- A per-register busy scoreboard tracks outstanding loads so the control unit can stall on read-after-load hazards.

Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- ADDR_W, 4, register address width; depth NREGS = 2**ADDR_W.
- BE_W, DATA_W/8, byte-lane count; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_a_addr  in  ADDR_W  read port A address (R_Bus).
- rd_a_data  out  DATA_W  read port A data.
- rd_b_addr  in  ADDR_W  read port B address (S_Bus).
- rd_b_data  out  DATA_W  read port B data.
- busy_a  out  1  register at rd_a_addr has a pending load.
- busy_b  out  1  register at rd_b_addr has a pending load.
- wa_en  in  1  write port A enable.
- wa_addr  in  ADDR_W  write port A address.
- wa_be  in  BE_W  write port A byte-lane enables; bit i covers data[8i+7:8i].
- wa_data  in  DATA_W  write port A data.
- wb_en  in  1  write port B enable (load return); clears busy.
- wb_addr  in  ADDR_W  write port B address.
- wb_data  in  DATA_W  write port B data.
- sb_set  in  1  load issued; mark sb_addr busy.
- sb_addr  in  ADDR_W  scoreboard set address.
- sb_err  out  1  sticky: load return to a non-busy register.

Behaviour:
- Reset (async, rst=1):
  - all registers become 0; all busy bits become 0; sb_err becomes 0.
  - Outputs are therefore rd_*_data=0, busy_*=0 while rst is held.
  - A write in flight at rst assertion is discarded.
- Reads: combinational from storage; zero-cycle latency.
- Write timing: writes commit on the rising clk edge and are visible to reads from the next cycle.
- Port A lane rule:
  - lane i written iff wa_en & wa_be[i]; other lanes keep their value.
  - wa_en=1 with wa_be=0 is a no-op.
- Port B: writes all lanes when wb_en=1.
- Same-address, same-cycle A+B (wa_addr==wb_addr):
  - lanes enabled on A take wa_data; remaining lanes take wb_data.
  - Both ports' effects apply; there is no priority drop of a whole port. This replaces the old exclusive if/else-if chain.
- Different addresses: both writes commit independently in the same cycle.
- Scoreboard: one busy bit per register.
  - sb_set=1: busy[sb_addr] is set at the edge.
  - wb_en=1: busy[wb_addr] is cleared at the edge.
  - sb_set and wb_en to the same address in the same cycle: set wins; busy stays 1 (new load overlaps the returning one).
  - wb_en to a register whose busy bit is 0: write still performed; sb_err is set and held until rst.
  - busy_a = busy[rd_a_addr]; busy_b = busy[rd_b_addr] (pre-bypass definition).
- Port A write to a busy register: performed; busy is unaffected; this is not an error.
- No register is hardwired to zero.

Optional Feature:
- Macro: BANKED_RF_BYPASS_EN.
- Defined, read data: rd_x_data returns the post-merge same-cycle write value when that port's address matches wa_addr and/or wb_addr. Lane merge follows the same rule as storage.
- Defined, busy: busy_x is forced to 0 when wb_en=1 and wb_addr==rd_x_addr, unless sb_set targets the same address in that cycle.
- Undefined: reads and busy reflect stored state only; one-cycle write-to-read latency.

Decomposition:
- Package banked_rf_pkg holds:
  - DATA_W/ADDR_W defaults.
  - a BE_W derivation function.
  - typedefs rf_addr_t, rf_word_t, rf_be_t.
  - the lane-merge function shared by storage and bypass.
- Sub-module rf_scoreboard:
  - contains busy bits, set/clear priority and sb_err.
  - exposes a busy vector to the top for read-port lookup.

Test Plan:
- Reset then read all 16 addresses -> all 0, busy_a=busy_b=0, sb_err=0.
- wa_en, addr 3, be=2'b10, data 0xABCD over stored 0x1234 -> next cycle rd_a(3)=0xAB34.
- Same cycle: wa addr 5 be=01 data 0x00EE and wb addr 5 data 0x7711 -> R5=0x77EE.
- sb_set addr 7 -> busy_a(7)=1.
  - Then wb_en addr 7 with sb_set addr 7 in the same cycle -> busy stays 1.
  - Next lone wb_en -> busy 0, sb_err 0.
- wb_en addr 9 with R9 not busy -> R9 written, sb_err=1 and held until rst.
- With BANKED_RF_BYPASS_EN defined: wb addr 2 data 0x5A5A with rd_b_addr=2 in the same cycle -> rd_b_data=0x5A5A, busy_b=0.
  - Without the macro: rd_b_data shows the old value until the next cycle.

Source files
------------

// File: rtl/banked_rf_pkg.sv
// Shared widths, types and the byte-lane merge used by storage and bypass
// of the banked register file.
package banked_rf_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   // Upper bounds for the width-generic lane merge; callers zero-extend.
   localparam int MAX_DATA_W = 512;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   typedef logic [ADDR_W_DEF-1:0]      rf_addr_t;
   typedef logic [DATA_W_DEF-1:0]      rf_word_t;
   typedef logic [DATA_W_DEF/8-1:0]    rf_be_t;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

   function automatic logic [MAX_DATA_W-1:0] lane_merge(
      input logic [MAX_DATA_W-1:0] new_w,
      input logic [MAX_DATA_W-1:0] old_w,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] r;
      r = old_w;
      for (int i = 0; i < MAX_BE_W; i++) begin
         r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for outstanding loads plus the sticky
// load-return-to-idle-register error flag.
module rf_scoreboard
   import banked_rf_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   sb_set_i,
   input  logic [ADDR_W-1:0]      sb_addr_i,
   input  logic                   wb_en_i,
   input  logic [ADDR_W-1:0]      wb_addr_i,
   output logic [2**ADDR_W-1:0]   busy_o,
   output logic                   sb_err_o
);

   localparam int NREGS = 2**ADDR_W;

   logic [NREGS-1:0] busy_q, busy_d;
   logic             err_q, err_d;

   // A new load issued to the returning register overlaps it, so set beats clear.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         busy_d[i] = (sb_set_i && (sb_addr_i == ADDR_W'(i))) ? 1'b1 :
                     (wb_en_i  && (wb_addr_i == ADDR_W'(i))) ? 1'b0 :
                     busy_q[i];
      end
      err_d = err_q | (wb_en_i & ~busy_q[wb_addr_i]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q <= {NREGS{1'b0}};
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_o   = busy_q;
   assign sb_err_o = err_q;

endmodule

// File: rtl/banked_register_file.sv
// Two-read / two-write register file with byte-lane writeback and a load
// scoreboard. Define BANKED_RF_BYPASS_EN for same-cycle write-to-read bypass.
module banked_register_file
   import banked_rf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      rd_a_addr,
   output logic [DATA_W-1:0]      rd_a_data,
   input  logic [ADDR_W-1:0]      rd_b_addr,
   output logic [DATA_W-1:0]      rd_b_data,
   output logic                   busy_a,
   output logic                   busy_b,
   input  logic                   wa_en,
   input  logic [ADDR_W-1:0]      wa_addr,
   input  logic [DATA_W/8-1:0]    wa_be,
   input  logic [DATA_W-1:0]      wa_data,
   input  logic                   wb_en,
   input  logic [ADDR_W-1:0]      wb_addr,
   input  logic [DATA_W-1:0]      wb_data,
   input  logic                   sb_set,
   input  logic [ADDR_W-1:0]      sb_addr,
   output logic                   sb_err
);

   localparam int BE_W  = be_width(DATA_W);
   localparam int NREGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [NREGS-1:0]  busy_vec;

   function automatic logic [DATA_W-1:0] merge_w(
      input logic [DATA_W-1:0] new_w,
      input logic [DATA_W-1:0] old_w,
      input logic [BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] n_x, o_x, m_x;
      logic [MAX_BE_W-1:0]   b_x;
      n_x = {MAX_DATA_W{1'b0}};
      o_x = {MAX_DATA_W{1'b0}};
      b_x = {MAX_BE_W{1'b0}};
      n_x[DATA_W-1:0] = new_w;
      o_x[DATA_W-1:0] = old_w;
      b_x[BE_W-1:0]   = be;
      m_x = lane_merge(n_x, o_x, b_x);
      return m_x[DATA_W-1:0];
   endfunction

   // Port B supplies the base word; port A lanes are then merged on top.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regs_d[i] = merge_w(
            wa_data,
            (wb_en && (wb_addr == ADDR_W'(i))) ? wb_data : regs_q[i],
            (wa_en && (wa_addr == ADDR_W'(i))) ? wa_be : {BE_W{1'b0}});
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   rf_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk_i     (clk),
      .rst_i     (rst),
      .sb_set_i  (sb_set),
      .sb_addr_i (sb_addr),
      .wb_en_i   (wb_en),
      .wb_addr_i (wb_addr),
      .busy_o    (busy_vec),
      .sb_err_o  (sb_err)
   );

`ifdef BANKED_RF_BYPASS_EN
   logic kill_a, kill_b;

   // A returning load clears the hazard early unless a new load re-arms it.
   assign kill_a = wb_en && (wb_addr == rd_a_addr) && !(sb_set && (sb_addr == rd_a_addr));
   assign kill_b = wb_en && (wb_addr == rd_b_addr) && !(sb_set && (sb_addr == rd_b_addr));

   assign rd_a_data = rst ? {DATA_W{1'b0}} : regs_d[rd_a_addr];
   assign rd_b_data = rst ? {DATA_W{1'b0}} : regs_d[rd_b_addr];
   assign busy_a    = busy_vec[rd_a_addr] & ~kill_a;
   assign busy_b    = busy_vec[rd_b_addr] & ~kill_b;
`else
   assign rd_a_data = regs_q[rd_a_addr];
   assign rd_b_data = regs_q[rd_b_addr];
   assign busy_a    = busy_vec[rd_a_addr];
   assign busy_b    = busy_vec[rd_b_addr];
`endif

endmodule

// File: tb/tb_banked_register_file.sv
// Self-checking bench for banked_register_file: directed scenarios followed by
// randomized traffic against a byte-lane array model.
module tb_banked_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  rd_a_addr, rd_b_addr;
   logic [15:0] rd_a_data, rd_b_data;
   logic        busy_a, busy_b;
   logic        wa_en;
   logic [3:0]  wa_addr;
   logic [1:0]  wa_be;
   logic [15:0] wa_data;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic        sb_set;
   logic [3:0]  sb_addr;
   logic        sb_err;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem  [16];
   logic        busy [16];
   logic        err;

   always #5 clk = ~clk;

   banked_register_file dut (
      .clk       (clk),
      .rst       (rst),
      .rd_a_addr (rd_a_addr),
      .rd_a_data (rd_a_data),
      .rd_b_addr (rd_b_addr),
      .rd_b_data (rd_b_data),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .wa_en     (wa_en),
      .wa_addr   (wa_addr),
      .wa_be     (wa_be),
      .wa_data   (wa_data),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .sb_set    (sb_set),
      .sb_addr   (sb_addr),
      .sb_err    (sb_err)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Value register r holds after this edge, built lane by lane.
   function automatic logic [15:0] model_next(input int r);
      logic [15:0] w;
      w = mem[r];
      for (int l = 0; l < 2; l++) begin
         if (wa_en && wa_addr == r[3:0] && wa_be[l])
            w[8*l +: 8] = wa_data[8*l +: 8];
         else if (wb_en && wb_addr == r[3:0])
            w[8*l +: 8] = wb_data[8*l +: 8];
      end
      return w;
   endfunction

   function automatic logic model_busy_next(input int r);
      if (sb_set && sb_addr == r[3:0]) return 1'b1;
      if (wb_en && wb_addr == r[3:0]) return 1'b0;
      return busy[r];
   endfunction

   function automatic logic exp_busy(input int r);
`ifdef BANKED_RF_BYPASS_EN
      if (wb_en && wb_addr == r[3:0] && !(sb_set && sb_addr == r[3:0])) return 1'b0;
`endif
      return busy[r];
   endfunction

   function automatic logic [15:0] exp_read(input int r);
`ifdef BANKED_RF_BYPASS_EN
      return model_next(r);
`else
      return mem[r];
`endif
   endfunction

   task automatic apply(input logic a_en, input logic [3:0] a_addr, input logic [1:0] a_be,
                        input logic [15:0] a_data, input logic b_en, input logic [3:0] b_addr,
                        input logic [15:0] b_data, input logic s_set, input logic [3:0] s_addr,
                        input logic [3:0] ra, input logic [3:0] rb);
      wa_en = a_en; wa_addr = a_addr; wa_be = a_be; wa_data = a_data;
      wb_en = b_en; wb_addr = b_addr; wb_data = b_data;
      sb_set = s_set; sb_addr = s_addr;
      rd_a_addr = ra; rd_b_addr = rb;
      #1;
      check("rd_a", rd_a_data, exp_read(int'(ra)));
      check("rd_b", rd_b_data, exp_read(int'(rb)));
      check("busy_a", {15'd0, busy_a}, {15'd0, exp_busy(int'(ra))});
      check("busy_b", {15'd0, busy_b}, {15'd0, exp_busy(int'(rb))});
      check("sb_err", {15'd0, sb_err}, {15'd0, err});
   endtask

   task automatic commit();
      logic [15:0] nm [16];
      logic        nb [16];
      logic        ne;
      for (int r = 0; r < 16; r++) begin
         nm[r] = model_next(r);
         nb[r] = model_busy_next(r);
      end
      ne = err | (wb_en && !busy[wb_addr]);
      @(posedge clk);
      for (int r = 0; r < 16; r++) begin
         mem[r]  = nm[r];
         busy[r] = nb[r];
      end
      err = ne;
      @(negedge clk);
   endtask

   task automatic idle_read(input logic [3:0] ra, input logic [3:0] rb);
      apply(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, ra, rb);
      commit();
   endtask

   task automatic model_reset();
      for (int r = 0; r < 16; r++) begin
         mem[r]  = 16'h0000;
         busy[r] = 1'b0;
      end
      err = 1'b0;
   endtask

   initial begin
      logic [3:0]  a_addr, b_addr, s_addr;
      rst = 1'b1;
      wa_en = 1'b0; wa_addr = 4'd0; wa_be = 2'b00; wa_data = 16'h0000;
      wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0000;
      sb_set = 1'b0; sb_addr = 4'd0;
      rd_a_addr = 4'd0; rd_b_addr = 4'd0;
      model_reset();

      // Reset and full sweep
      #12;
      check("rst_rd_a", rd_a_data, 16'h0000);
      check("rst_err", {15'd0, sb_err}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));

      // Port A lane write over a full word
      apply(1'b1, 4'd3, 2'b11, 16'h1234, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd0);
      commit();
      apply(1'b1, 4'd3, 2'b10, 16'hABCD, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3);
      commit();
      idle_read(4'd3, 4'd3);
      #0 rd_a_addr = 4'd3; #1 check("lane_r3", rd_a_data, 16'hAB34);
      // wa_en with no lanes is a no-op
      apply(1'b1, 4'd3, 2'b00, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd3, 4'd3);
      commit();
      idle_read(4'd3, 4'd0);

      // Scoreboard: set, overlapped set+return, lone return
      apply(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7, 4'd7);
      commit();
      idle_read(4'd7, 4'd0);
      check("busy7_set", {15'd0, busy_a}, 16'h0001);
      apply(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 4'd7, 4'd7);
      commit();
      idle_read(4'd7, 4'd7);
      check("busy7_overlap", {15'd0, busy_a}, 16'h0001);
      apply(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 16'h2222, 1'b0, 4'd0, 4'd7, 4'd7);
      commit();
      idle_read(4'd7, 4'd7);
      check("busy7_clear", {15'd0, busy_a}, 16'h0000);
      check("err_clean", {15'd0, sb_err}, 16'h0000);

      // Same-address A+B merge (R5 made busy so the return is legal)
      apply(1'b0, 4'd0, 2'b00, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 4'd5, 4'd5);
      commit();
      apply(1'b1, 4'd5, 2'b01, 16'h00EE, 1'b1, 4'd5, 16'h7711, 1'b0, 4'd0, 4'd5, 4'd5);
      commit();
      idle_read(4'd5, 4'd5);
      #0 rd_a_addr = 4'd5; #1 check("merge_r5", rd_a_data, 16'h77EE);

      // Load return to an idle register raises the sticky error
      apply(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd9, 16'hC0DE, 1'b0, 4'd0, 4'd9, 4'd9);
      commit();
      idle_read(4'd9, 4'd0);
      check("err_set", {15'd0, sb_err}, 16'h0001);
      idle_read(4'd0, 4'd9);
      check("err_held", {15'd0, sb_err}, 16'h0001);

      // Same-cycle read of a load return
      apply(1'b1, 4'd2, 2'b11, 16'h1111, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd2);
      commit();
      apply(1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd2, 16'h5A5A, 1'b0, 4'd0, 4'd0, 4'd2);
`ifdef BANKED_RF_BYPASS_EN
      check("bypass_rd_b", rd_b_data, 16'h5A5A);
`else
      check("nobypass_rd_b", rd_b_data, 16'h1111);
`endif
      check("bypass_busy_b", {15'd0, busy_b}, 16'h0000);
      commit();
      idle_read(4'd2, 4'd2);

      // Randomized traffic, addresses biased toward a small window for collisions
      for (int n = 0; n < 400; n++) begin
         a_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         b_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         s_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         apply(1'($urandom_range(0, 1)), a_addr, 2'($urandom_range(0, 3)), 16'($urandom),
               1'($urandom_range(0, 2) == 0), b_addr, 16'($urandom),
               1'($urandom_range(0, 2) == 0), s_addr,
               ($urandom_range(0, 1) == 0) ? a_addr : 4'($urandom_range(0, 15)),
               ($urandom_range(0, 1) == 0) ? b_addr : 4'($urandom_range(0, 15)));
         commit();
      end

      // Asynchronous reset mid-cycle discards the in-flight write
      apply(1'b1, 4'd1, 2'b11, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd1, 4'd1, 4'd9);
      #1 rst = 1'b1;
      #1;
      check("arst_rd_a", rd_a_data, 16'h0000);
      check("arst_rd_b", rd_b_data, 16'h0000);
      check("arst_busy", {15'd0, busy_a}, 16'h0000);
      check("arst_err", {15'd0, sb_err}, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(i ^ 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
